// File: rtl/seven_seg_pkg.sv
//============================================================================
// Module : seven_seg_pkg
// Brief  : Shared seven-segment code table, default geometry and decoder
//          FSM state type (common to encoder and decoder).
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

package seven_seg_pkg;

    localparam int unsigned DEF_NUM_DIGITS = 6;
    localparam int unsigned DEF_SEG_W      = 7;

    // Active-low codes, bit0=a .. bit6=g
    localparam logic [6:0] SEG_CODE_0 = 7'h40;
    localparam logic [6:0] SEG_CODE_1 = 7'h79;
    localparam logic [6:0] SEG_CODE_2 = 7'h24;
    localparam logic [6:0] SEG_CODE_3 = 7'h30;
    localparam logic [6:0] SEG_CODE_4 = 7'h19;
    localparam logic [6:0] SEG_CODE_5 = 7'h12;
    localparam logic [6:0] SEG_CODE_6 = 7'h02;
    localparam logic [6:0] SEG_CODE_7 = 7'h78;
    localparam logic [6:0] SEG_CODE_8 = 7'h00;
    localparam logic [6:0] SEG_CODE_9 = 7'h10;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DEC  = 1'b1
    } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/seven_seg_digit_decode.sv
//============================================================================
// Module : seven_seg_digit_decode
// Brief  : Combinational 7-bit active-low segment code -> {legal, digit}.
//          SEVEN_SEG_BLANK_AS_ZERO_EN makes the all-off code a legal zero.
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module seven_seg_digit_decode
    import seven_seg_pkg::*;
(
    input  logic [DEF_SEG_W-1:0] i_code,
    output logic                 o_legal,
    output logic [3:0]           o_digit
);

    always_comb begin
        o_legal = 1'b1;
        o_digit = 4'd0;
        case (i_code)
            SEG_CODE_0: o_digit = 4'd0;
            SEG_CODE_1: o_digit = 4'd1;
            SEG_CODE_2: o_digit = 4'd2;
            SEG_CODE_3: o_digit = 4'd3;
            SEG_CODE_4: o_digit = 4'd4;
            SEG_CODE_5: o_digit = 4'd5;
            SEG_CODE_6: o_digit = 4'd6;
            SEG_CODE_7: o_digit = 4'd7;
            SEG_CODE_8: o_digit = 4'd8;
            SEG_CODE_9: o_digit = 4'd9;
`ifdef SEVEN_SEG_BLANK_AS_ZERO_EN
            SEG_BLANK:  o_digit = 4'd0;
`endif
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seven_segment_decoder.sv
//============================================================================
// Module : seven_segment_decoder
// Brief  : Captures a multi-digit active-low segment bus and rebuilds the
//          displayed decimal value, one digit per clock, MSD first.
//          Option macro: SEVEN_SEG_BLANK_AS_ZERO_EN (blank field = legal 0).
// Rev    : 1.0 - initial release
//============================================================================
`default_nettype none

module seven_segment_decoder
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned SEG_W      = DEF_SEG_W,
    parameter int unsigned NUM_W      = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        segs_vld,
    input  logic [NUM_DIGITS*SEG_W-1:0] segs,
    output logic                        busy,
    output logic [NUM_W-1:0]            num,
    output logic                        num_vld,
    output logic                        err,
    output logic [NUM_DIGITS-1:0]       err_mask,
    output logic                        ovr
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] C_IDX_MSD = IDX_W'(NUM_DIGITS - 1);

    dec_state_t                  r_state;
    dec_state_t                  w_state_nxt;
    logic [NUM_DIGITS*SEG_W-1:0] r_shadow;
    logic [IDX_W-1:0]            r_idx;
    logic [NUM_W-1:0]            r_acc;
    logic [NUM_DIGITS-1:0]       r_mask_acc;
    logic [NUM_W-1:0]            r_num;
    logic                        r_num_vld;
    logic                        r_err;
    logic [NUM_DIGITS-1:0]       r_err_mask;
    logic                        r_ovr;

    logic [SEG_W-1:0]            w_fields [NUM_DIGITS];
    logic                        w_legal;
    logic [3:0]                  w_digit;
    logic                        w_accept;
    logic                        w_last;
    logic [NUM_W-1:0]            w_acc_nxt;
    logic [NUM_DIGITS-1:0]       w_mask_nxt;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_field
        assign w_fields[k] = r_shadow[k*SEG_W +: SEG_W];
    end

    seven_seg_digit_decode u_digit_decode (
        .i_code  (w_fields[r_idx]),
        .o_legal (w_legal),
        .o_digit (w_digit)
    );

    // acc*10 as shift-add keeps the datapath multiplier-free
    assign w_acc_nxt = (r_acc << 3) + (r_acc << 1) + NUM_W'(w_digit);

    always_comb begin
        w_state_nxt       = r_state;
        w_accept          = 1'b0;
        w_last            = 1'b0;
        w_mask_nxt        = r_mask_acc;
        w_mask_nxt[r_idx] = ~w_legal;
        case (r_state)
            IDLE: begin
                if (segs_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DEC;
                end
            end
            DEC: begin
                if (r_idx == '0) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_mask_acc <= '0;
            r_num      <= '0;
            r_num_vld  <= 1'b0;
            r_err      <= 1'b0;
            r_err_mask <= '0;
            r_ovr      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_num_vld <= w_last;
            if (w_accept) begin
                r_shadow   <= segs;
                r_acc      <= '0;
                r_idx      <= C_IDX_MSD;
                r_mask_acc <= '0;
            end else if (r_state == DEC) begin
                r_acc      <= w_acc_nxt;
                r_idx      <= r_idx - 1'b1;
                r_mask_acc <= w_mask_nxt;
                if (w_last) begin
                    r_num      <= w_acc_nxt;
                    r_err_mask <= w_mask_nxt;
                    r_err      <= |w_mask_nxt;
                end
            end
            // Requests arriving mid-decode are dropped but remembered
            if (segs_vld && (r_state == DEC)) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign busy     = (r_state == DEC);
    assign num      = r_num;
    assign num_vld  = r_num_vld;
    assign err      = r_err;
    assign err_mask = r_err_mask;
    assign ovr      = r_ovr;

endmodule

`default_nettype wire
